// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared defaults and the per-stage payload layout for the pipelined
// adder/subtractor.
//   DEF_WIDTH / DEF_SEG_W : default operand width and segment width
//   stage_t               : what one pipeline stage carries forward
// -----------------------------------------------------------------------------
package adder_pkg;

  localparam int unsigned DEF_WIDTH  = 16;
  localparam int unsigned DEF_SEG_W  = 4;
  localparam int unsigned DEF_STAGES = DEF_WIDTH / DEF_SEG_W;

  // One stage's payload at the default sizing: valid, low sum bits produced
  // so far, segment carry, and the still-unconsumed upper operand bits.
  typedef struct packed {
    logic                 valid;
    logic [DEF_WIDTH-1:0] sum;
    logic                 carry;
    logic [DEF_WIDTH-1:0] a_hi;
    logic [DEF_WIDTH-1:0] b_hi;
  } stage_t;

endpackage

// File: rtl/adder_seg.sv
// -----------------------------------------------------------------------------
// adder_seg
// Combinational SEG_W-bit adder slice used once per pipeline stage.
//   a_i, b_i : segment operands
//   cin_i    : carry into the segment
//   sum_o    : segment sum
//   cout_o   : carry out of the segment MSB
//   cmsb_o   : carry into the segment MSB (feeds signed overflow)
// -----------------------------------------------------------------------------
module adder_seg
  import adder_pkg::*;
#(
  parameter int unsigned SEG_W = DEF_SEG_W
) (
  input  logic [SEG_W-1:0] a_i,
  input  logic [SEG_W-1:0] b_i,
  input  logic             cin_i,
  output logic [SEG_W-1:0] sum_o,
  output logic             cout_o,
  output logic             cmsb_o
);

  localparam int unsigned SUM_W = SEG_W + 1;

  logic [SEG_W:0] full_c;

  // The carry into the MSB is recovered from the MSB sum bit: s = a ^ b ^ c.
  always_comb begin
    full_c = {1'b0, a_i} + {1'b0, b_i} + SUM_W'(cin_i);
    sum_o  = full_c[SEG_W-1:0];
    cout_o = full_c[SEG_W];
    cmsb_o = full_c[SEG_W-1] ^ a_i[SEG_W-1] ^ b_i[SEG_W-1];
  end

endmodule

// File: rtl/adder_pipe.sv
// -----------------------------------------------------------------------------
// adder_pipe
// Pipelined two's-complement adder/subtractor, one SEG_W segment per stage,
// with a valid/ready stream on both sides.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   valid_i / ready_o    : operand handshake (ready_o = !valid_o || ready_i)
//   a_i, b_i             : operands
//   carry_i              : carry in (add) / borrow in (sub)
//   sub_i                : 0 = A+B+carry_i, 1 = A-B-carry_i
//   valid_o / ready_i    : result handshake
//   sum_o, carry_o       : result and carry out (sub: 1 = no borrow)
//   ovf_o, zero_o        : signed overflow, result-is-zero
// -----------------------------------------------------------------------------
module adder_pipe
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SEG_W = DEF_SEG_W
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
  input  logic             sub_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             ovf_o,
  output logic             zero_o
);

  localparam int unsigned STAGES = WIDTH / SEG_W;
  // Operand remainders are only needed between stages; keep one slot minimum.
  localparam int unsigned REST_N = (STAGES > 1) ? STAGES - 1 : 1;

  if ((SEG_W < 1) || ((WIDTH % SEG_W) != 0)) begin : g_param_check
    $error("adder_pipe: WIDTH (%0d) must be a nonzero multiple of SEG_W (%0d)",
           WIDTH, SEG_W);
  end

  logic                           en_c;
  logic [WIDTH-1:0]               b_eff_c;

  logic [STAGES-1:0]              valid_q, valid_d;
  logic [STAGES-1:0][WIDTH-1:0]   sum_q, sum_d;
  logic [STAGES-1:0]              carry_q, carry_d;
  logic [REST_N-1:0][WIDTH-1:0]   a_rest_q, a_rest_d;
  logic [REST_N-1:0][WIDTH-1:0]   b_rest_q, b_rest_d;
  logic                           ovf_q, ovf_d;
  logic                           zero_q, zero_d;

  // Inputs seen by each stage: the ports for stage 0, the previous stage's
  // registers otherwise.
  logic [STAGES-1:0]              valid_in_c;
  logic [STAGES-1:0][WIDTH-1:0]   sum_in_c;
  logic [STAGES-1:0][WIDTH-1:0]   op_a_c, op_b_c;
  logic [STAGES-1:0]              cin_c;

  logic [STAGES-1:0][SEG_W-1:0]   seg_sum_c;
  logic [STAGES-1:0]              seg_cout_c;
  logic [STAGES-1:0]              seg_cmsb_c;

  // Whole pipeline advances or holds as one; no bubble compression.
  assign en_c    = !valid_o || ready_i;
  assign ready_o = en_c;
  assign b_eff_c = sub_i ? ~b_i : b_i;

  // Stage input selection.
  always_comb begin
    valid_in_c    = '0;
    sum_in_c      = '0;
    op_a_c        = '0;
    op_b_c        = '0;
    cin_c         = '0;
    valid_in_c[0] = valid_i;
    op_a_c[0]     = a_i;
    op_b_c[0]     = b_eff_c;
    cin_c[0]      = carry_i ^ sub_i;
    for (int unsigned k = 1; k < STAGES; k++) begin
      valid_in_c[k] = valid_q[k-1];
      sum_in_c[k]   = sum_q[k-1];
      op_a_c[k]     = a_rest_q[k-1];
      op_b_c[k]     = b_rest_q[k-1];
      cin_c[k]      = carry_q[k-1];
    end
  end

  // One segment adder per stage; each consumes the low SEG_W operand bits.
  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    adder_seg #(
      .SEG_W (SEG_W)
    ) u_seg (
      .a_i    (op_a_c[k][SEG_W-1:0]),
      .b_i    (op_b_c[k][SEG_W-1:0]),
      .cin_i  (cin_c[k]),
      .sum_o  (seg_sum_c[k]),
      .cout_o (seg_cout_c[k]),
      .cmsb_o (seg_cmsb_c[k])
    );
  end

  // Next-state for all stages plus the final-stage flags.
  always_comb begin
    valid_d  = valid_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    a_rest_d = a_rest_q;
    b_rest_d = b_rest_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    if (en_c) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        valid_d[k] = valid_in_c[k];
        sum_d[k]   = sum_in_c[k] | (WIDTH'(seg_sum_c[k]) << (k * SEG_W));
        carry_d[k] = seg_cout_c[k];
        if (k == STAGES - 1) begin
          ovf_d = seg_cmsb_c[k] ^ seg_cout_c[k];
        end
      end
      for (int unsigned k = 0; k + 1 < STAGES; k++) begin
        a_rest_d[k] = op_a_c[k] >> SEG_W;
        b_rest_d[k] = op_b_c[k] >> SEG_W;
      end
      zero_d = (sum_d[STAGES-1] == '0);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= '0;
      sum_q    <= '0;
      carry_q  <= '0;
      a_rest_q <= '0;
      b_rest_q <= '0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      a_rest_q <= a_rest_d;
      b_rest_q <= b_rest_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign valid_o = valid_q[STAGES-1];
  assign sum_o   = sum_q[STAGES-1];
  assign carry_o = carry_q[STAGES-1];
  assign ovf_o   = ovf_q;
  assign zero_o  = zero_q;

endmodule

// File: tb/tb_adder_pipe.sv
// Testbench for adder_pipe: 16/4 and 8/8 configurations side by side.
module tb_adder_pipe;

  localparam int unsigned LAT16 = 16 / 4 - 1;
  localparam int unsigned LAT8  = 8 / 8 - 1;

  typedef struct {
    logic [15:0] sum;
    logic        c;
    logic        v;
    logic        z;
  } res_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        c;
    logic        v;
    logic        z;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        v_in16, r_out16, c16, s16, v_out16, r_in16, co16, ov16, z16;
  logic [15:0] a16, b16, sum16;
  logic        v_in8, r_out8, c8, s8, v_out8, r_in8, co8, ov8, z8;
  logic [7:0]  a8, b8, sum8;

  adder_pipe #(.WIDTH(16), .SEG_W(4)) dut16 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(v_in16), .ready_o(r_out16),
    .a_i(a16), .b_i(b16), .carry_i(c16), .sub_i(s16),
    .valid_o(v_out16), .ready_i(r_in16), .sum_o(sum16), .carry_o(co16),
    .ovf_o(ov16), .zero_o(z16)
  );

  adder_pipe #(.WIDTH(8), .SEG_W(8)) dut8 (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(v_in8), .ready_o(r_out8),
    .a_i(a8), .b_i(b8), .carry_i(c8), .sub_i(s8),
    .valid_o(v_out8), .ready_i(r_in8), .sum_o(sum8), .carry_o(co8),
    .ovf_o(ov8), .zero_o(z8)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed readings.
  function automatic res_t model(input int unsigned w, input longint a, input longint b,
                                 input logic cin, input logic sub);
    res_t   r;
    longint m, half, ci, u, sa, sb, s;
    m    = longint'(1) << w;
    half = m / 2;
    ci   = cin ? 1 : 0;
    u    = sub ? (a - b - ci) : (a + b + ci);
    sa   = (a >= half) ? a - m : a;
    sb   = (b >= half) ? b - m : b;
    s    = sub ? (sa - sb - ci) : (sa + sb + ci);
    r.sum = 16'(u & (m - 1));
    r.c   = sub ? (u >= 0) : (u >= m);
    r.v   = (s < -half) || (s >= half);
    r.z   = ((u & (m - 1)) == 0);
    return r;
  endfunction

  task automatic drive(input bit w8, input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic s);
    if (w8) begin
      v_in8 = v; a8 = a[7:0]; b8 = b[7:0]; c8 = c; s8 = s;
    end else begin
      v_in16 = v; a16 = a; b16 = b; c16 = c; s16 = s;
    end
  endtask

  task automatic sample(input bit w8, output logic v, output res_t r);
    if (w8) begin
      v = v_out8; r.sum = {8'h00, sum8}; r.c = co8; r.v = ov8; r.z = z8;
    end else begin
      v = v_out16; r.sum = sum16; r.c = co16; r.v = ov16; r.z = z16;
    end
  endtask

  task automatic cmp_res(input string tag, input res_t act, input res_t exp);
    check({tag, "_sum"},   32'(act.sum), 32'(exp.sum));
    check({tag, "_carry"}, 32'(act.c),   32'(exp.c));
    check({tag, "_ovf"},   32'(act.v),   32'(exp.v));
    check({tag, "_zero"},  32'(act.z),   32'(exp.z));
  endtask

  // Single operation on an idle pipe; checks acceptance, latency and result.
  task automatic run_one(input bit w8, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub, input res_t exp, input string tag);
    int   lat;
    logic v;
    res_t r;
    @(negedge clk);
    drive(w8, 1'b1, a, b, cin, sub);
    #1;
    check({tag, "_ready_o"}, w8 ? r_out8 : r_out16, 1);
    @(negedge clk);
    drive(w8, 1'b0, a, b, cin, sub);
    lat = 0;
    sample(w8, v, r);
    while (!v && lat < 20) begin
      @(negedge clk);
      lat++;
      sample(w8, v, r);
    end
    check({tag, "_latency"}, lat, w8 ? LAT8 : LAT16);
    cmp_res(tag, r, exp);
  endtask

  // Streaming on the 16-bit pipe against a FIFO of model results.
  // rnd=0: back-to-back ops, ready_i low for 3 cycles after the first result.
  task automatic stream(input int n_ops, input bit rnd, input string tag);
    res_t q[$];
    res_t e, r, snap;
    logic v, snap_v;
    int   sent = 0, got = 0, cyc = 0, stall_left = 0;
    bit   first_seen = 0, hold = 0, was_stall = 0;
    snap   = '{default: '0};
    snap_v = 1'b0;
    while (got < n_ops && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      sample(1'b0, v, r);
      if (was_stall) begin
        check({tag, "_stall_valid"}, v, snap_v);
        cmp_res({tag, "_stall_hold"}, r, snap);
      end
      if (rnd) begin
        r_in16 = ($urandom_range(0, 3) != 0);
      end else begin
        if (v && !first_seen) begin
          first_seen = 1;
          stall_left = 3;
        end
        r_in16 = (stall_left == 0);
        if (stall_left > 0) stall_left--;
      end
      if (!hold) begin
        if (sent < n_ops && (!rnd || $urandom_range(0, 3) != 0))
          drive(1'b0, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        else
          drive(1'b0, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      end
      #1;
      check({tag, "_ready_o"}, r_out16, !v || r_in16);
      if (v && r_in16) begin
        check({tag, "_out_expected"}, q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          cmp_res($sformatf("%s_res%0d", tag, got), r, e);
        end
        got++;
      end
      hold = 0;
      if (v_in16 && r_out16) begin
        q.push_back(model(16, a16, b16, c16, s16));
        sent++;
      end else if (v_in16) begin
        hold = 1;
      end
      was_stall = v && !r_in16;
      snap      = r;
      snap_v    = v;
    end
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    r_in16 = 1'b1;
    check({tag, "_count"}, got, n_ops);
    check({tag, "_leftover"}, q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t t16[8];
    vec_t t8[4];
    res_t e;
    logic [15:0] ra, rb;
    logic rc, rs;
    bit seen;

    t16[0] = '{16'd52215, 16'd39218, 1'b0, 1'b0, 16'd25897, 1'b1, 1'b1, 1'b0};
    t16[1] = '{16'd5,     16'd7,     1'b0, 1'b1, 16'hFFFE,  1'b0, 1'b0, 1'b0};
    t16[2] = '{16'hFFFF,  16'h0000,  1'b1, 1'b0, 16'h0000,  1'b1, 1'b0, 1'b1};
    t16[3] = '{16'h0FFF,  16'h0001,  1'b0, 1'b0, 16'h1000,  1'b0, 1'b0, 1'b0};
    t16[4] = '{16'h7FFF,  16'h0000,  1'b1, 1'b0, 16'h8000,  1'b0, 1'b1, 1'b0};
    t16[5] = '{16'h8000,  16'h0001,  1'b0, 1'b1, 16'h7FFF,  1'b1, 1'b1, 1'b0};
    t16[6] = '{16'h0000,  16'h0000,  1'b1, 1'b1, 16'hFFFF,  1'b0, 1'b0, 1'b0};
    t16[7] = '{16'h0005,  16'h0005,  1'b0, 1'b1, 16'h0000,  1'b1, 1'b0, 1'b1};
    t8[0]  = '{16'h00F7,  16'h0032,  1'b0, 1'b0, 16'h0029,  1'b1, 1'b0, 1'b0};
    t8[1]  = '{16'h0080,  16'h0001,  1'b0, 1'b1, 16'h007F,  1'b1, 1'b1, 1'b0};
    t8[2]  = '{16'h007F,  16'h0001,  1'b0, 1'b0, 16'h0080,  1'b0, 1'b1, 1'b0};
    t8[3]  = '{16'h00FF,  16'h0001,  1'b0, 1'b0, 16'h0000,  1'b1, 1'b0, 1'b1};

    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    r_in16 = 1'b1;
    r_in8  = 1'b1;

    // Reset state of both configurations.
    #12;
    check("rst16_valid_o", v_out16, 0);
    check("rst16_sum_o",   sum16,   0);
    check("rst16_carry_o", co16,    0);
    check("rst16_ovf_o",   ov16,    0);
    check("rst16_zero_o",  z16,     0);
    check("rst16_ready_o", r_out16, 1);
    check("rst8_valid_o",  v_out8,  0);
    check("rst8_sum_o",    sum8,    0);
    check("rst8_ready_o",  r_out8,  1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors.
    for (int i = 0; i < 8; i++) begin
      e = '{t16[i].sum, t16[i].c, t16[i].v, t16[i].z};
      run_one(1'b0, t16[i].a, t16[i].b, t16[i].cin, t16[i].sub, e, $sformatf("vec16_%0d", i));
    end
    for (int i = 0; i < 4; i++) begin
      e = '{t8[i].sum, t8[i].c, t8[i].v, t8[i].z};
      run_one(1'b1, t8[i].a, t8[i].b, t8[i].cin, t8[i].sub, e, $sformatf("vec8_%0d", i));
    end

    // Random single operations against the model.
    for (int i = 0; i < 10; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rs = 1'($urandom);
      run_one(1'b0, ra, rb, rc, rs, model(16, ra, rb, rc, rs), $sformatf("rnd16_%0d", i));
      ra = {8'h00, 8'($urandom)}; rb = {8'h00, 8'($urandom)};
      run_one(1'b1, ra, rb, rc, rs, model(8, ra, rb, rc, rs), $sformatf("rnd8_%0d", i));
    end

    // Streaming: directed back-pressure, then random valid/ready.
    stream(8, 1'b0, "bp8");
    stream(300, 1'b1, "rstream");

    // Reset with three operations in flight.
    @(negedge clk);
    r_in16 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check("midrst_pre_valid", v_out16, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid_o", v_out16, 0);
    check("midrst_sum_o",   sum16,   0);
    check("midrst_carry_o", co16,    0);
    check("midrst_ovf_o",   ov16,    0);
    check("midrst_zero_o",  z16,     0);
    check("midrst_ready_o", r_out16, 1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (v_out16) seen = 1;
    end
    check("midrst_no_stale", seen, 0);
    ra = 16'h1234; rb = 16'h4321;
    run_one(1'b0, ra, rb, 1'b1, 1'b1, model(16, ra, rb, 1'b1, 1'b1), "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_pipe.md
# adder_pipe

Parametrised, pipelined two's-complement adder/subtractor with a valid/ready stream interface. It is the sequential successor to the combinational 8-bit carry adder. Operands are split into SEG_W-bit segments, one segment per pipeline stage, with the carry registered between stages. It runs at full throughput and accepts back-pressure. It sits in the datapath ahead of the ALU and accumulator blocks and produces sum, carry, signed-overflow and zero flags.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of SEG_W.
- SEG_W, 4, segment width per stage; STAGES = WIDTH/SEG_W (derived, not overridable).
- clk_i  input  1  single clock; all state updates on rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- valid_i  input  1  operand set present.
- ready_o  output  1  block can accept operands this cycle.
- a_i  input  WIDTH  operand A.
- b_i  input  WIDTH  operand B.
- carry_i  input  1  carry in (add); borrow in (sub).
- sub_i  input  1  0: A+B+carry_i; 1: A−B−carry_i.
- valid_o  output  1  result present.
- ready_i  input  1  downstream accepts result.
- sum_o  output  WIDTH  result.
- carry_o  output  1  carry out of MSB; for sub, 1 means no borrow.
- ovf_o  output  1  signed overflow.
- zero_o  output  1  sum_o == 0.

## Operation
- Effective operand: b_eff = sub_i ? ~b_i : b_i. Carry into segment 0: cin = carry_i ^ sub_i.
- Stage k (1..STAGES) adds segment k−1 of A and b_eff plus the carry registered by stage k−1.
- Each stage registers: valid, the accumulated low k·SEG_W sum bits, the segment carry, and the not-yet-used upper bits of A and b_eff.
- The final stage additionally registers:
  - ovf = carry into MSB XOR carry out of MSB;
  - zero = (full sum == 0).
- All outputs are driven directly from the final-stage registers. There is no combinational path from inputs to sum_o, carry_o, ovf_o, zero_o or valid_o.
- Advance enable: en = !valid_o || ready_i.
  - ready_o = en.
  - All stages shift together when en is 1 and all hold when en is 0.
  - Bubbles are not compressed.
- Transfer in when valid_i && ready_o. Transfer out when valid_o && ready_i.
- Results leave in acceptance order. None are dropped or duplicated.
- Elaboration check: $error if WIDTH % SEG_W != 0 or SEG_W < 1.

## Timing
- Reset (rst_ni low, asynchronous):
  - every valid bit clears and all data registers clear to 0;
  - valid_o=0, sum_o=0, carry_o=0, ovf_o=0, zero_o=0;
  - ready_o=1, since it is derived from valid_o=0.
- Latency: operands accepted at edge t appear with valid_o=1 after edge t+STAGES−1.
  - WIDTH=16, SEG_W=4: accept at edge 0, result valid after edge 3.
  - SEG_W=WIDTH: result valid after the accepting edge itself.
- Throughput: one result per cycle while ready_i=1.
- Stall: while valid_o && !ready_i, ready_o=0 and every output stays stable. Inputs are ignored (valid_i may toggle).
- Simultaneous in/out: with valid_o && ready_i, a new operand is accepted on the same edge the result leaves.
- Reset mid-operation: all in-flight operations are discarded. No stale result appears after rst_ni is released.
- ready_i is the only input with a combinational path to an output (ready_o).

## Structure
- adder_pkg holds:
  - default WIDTH/SEG_W localparams;
  - the stage payload struct typedef (valid, sum, carry, upper A, upper b_eff), parametrised via the block's localparams.
- Sub-module adder_seg: combinational SEG_W-bit slice (a, b, cin → sum, cout, carry into MSB). It is instantiated once per stage inside a generate loop.
- adder_pipe holds all registers and the handshake logic.

## Test plan
- WIDTH=16: a_i=52215, b_i=39218, carry_i=0, sub_i=0 → sum_o=25897, carry_o=1, ovf_o=1, zero_o=0, valid after 3 edges.
- a_i=5, b_i=7, sub_i=1, carry_i=0 → sum_o=16'hFFFE, carry_o=0, ovf_o=0, zero_o=0.
- a_i=16'hFFFF, b_i=0, carry_i=1 → sum_o=0, carry_o=1, zero_o=1, ovf_o=0.
- Cross-segment ripple: a_i=16'h0FFF, b_i=16'h0001 → sum_o=16'h1000, carry_o=0.
- Streaming with back-pressure:
  - 8 back-to-back ops, ready_i low for 3 cycles after the first valid_o;
  - outputs hold and ready_o=0 during the stall;
  - all 8 results arrive in order, none lost.
- Reset with 3 ops in flight:
  - valid_o=0 and all outputs 0 immediately on rst_ni low;
  - after release, no result emerges until new operands are accepted.
- Repeat the first scenario with WIDTH=8, SEG_W=8 (a_i=8'hF7, b_i=8'h32 → sum_o=8'h29, carry_o=1, ovf_o=0, valid the cycle after accept).
